branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address/data width.
REQ-002 SHALL have parameter DEPTH, default 4, in-flight prediction entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pred_valid  input  1  fetch pushes one prediction this cycle.
REQ-006 SHALL have port pred_pc  input  WIDTH  PC of the predicted instruction.
REQ-007 SHALL have port pred_taken  input  1  predictor said taken.
REQ-008 SHALL have port pred_target  input  WIDTH  predicted next PC.
REQ-009 SHALL have port pred_ready  output  1  queue can accept a push (not full, not in FLUSH).
REQ-010 SHALL have port res_valid  input  1  execute stage resolves the oldest control instruction.
REQ-011 SHALL have port res_pc  input  WIDTH  PC being resolved.
REQ-012 SHALL have port res_branch  input  1  instruction is a conditional branch.
REQ-013 SHALL have port res_eq  input  1  branch condition true.
REQ-014 SHALL have port res_target  input  WIDTH  computed PC+imm.
REQ-015 SHALL have port flush  output  1  pipeline flush, registered.
REQ-016 SHALL have port redirect_pc  output  WIDTH  correct next PC, valid with flush.
REQ-017 SHALL have port upd_valid/upd_pc/upd_taken/upd_target  output  1/WIDTH/1/WIDTH  predictor training write.
REQ-018 SHALL have port err  output  1  sticky protocol error.

Function
REQ-019 SHALL hold predictions in a DEPTH-entry FIFO; push when pred_valid && pred_ready; pop on every res_valid with non-empty FIFO.
REQ-020 Actual outcome SHALL be taken = res_branch && res_eq; actual next PC = taken ? res_target : res_pc+4, modulo 2^WIDTH.
REQ-021 Mispredict SHALL be head.pred_taken != taken, or (taken && head.pred_target != res_target).
REQ-022 PC mismatch (res_pc != head.pred_pc) SHALL set err and be handled as a mispredict.
REQ-023 res_valid with empty FIFO SHALL set err, produce no pop, no update and no flush.
REQ-024 upd_* SHALL be registered, asserted for exactly one cycle, one cycle after res_valid with res_branch=1 and non-empty FIFO.
REQ-025 FSM SHALL have states RUN and FLUSH; RUN->FLUSH on a mispredict; FLUSH->RUN unconditionally after one cycle.
REQ-026 In FLUSH: flush=1 and redirect_pc = actual next PC; the FIFO SHALL be emptied; pred_ready=0; res_valid ignored.
REQ-027 A push in the same cycle as a mispredicting resolve SHALL be discarded; a push in the same cycle as a correct resolve SHALL be accepted, keeping occupancy unchanged when full.
REQ-028 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from a (log2(DEPTH)+1)-bit count.
REQ-029 err SHALL be cleared only by reset.

Reset
REQ-030 On rst low, immediately: state RUN, FIFO empty, flush=0, redirect_pc=0, upd_valid=0, upd_pc=0, upd_taken=0, upd_target=0, err=0, pred_ready=1.
REQ-031 Reset asserted mid-FLUSH SHALL abort the flush with no further flush cycle.

Configuration
REQ-032 With BRES_STATS_EN defined: outputs stat_branches and stat_mispredicts (16-bit each) count resolved branches and mispredicts, saturating at 16'hFFFF, reset to 0.
REQ-033 Without BRES_STATS_EN: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-034 Package bpu_pkg SHALL hold pred_entry_t (pc, taken, target), the state enum bres_state_t {RUN, FLUSH}, and the constant INSTR_BYTES = 4.
REQ-035 The FIFO SHALL be a sub-module pred_fifo (push, pop, clear, full, empty, head).

Verification
REQ-036 Push pc=0x100 taken=1 target=0x140; resolve pc=0x100 branch=1 eq=1 target=0x140 -> no flush; upd_valid=1, upd_taken=1 next cycle.
REQ-037 Push pc=0x200 taken=0; resolve branch=1 eq=1 target=0x180 -> flush=1 for one cycle, redirect_pc=0x180, FIFO empty after.
REQ-038 Push pc=0x300 taken=1 target=0x320; resolve eq=0 -> flush, redirect_pc=0x304, upd_taken=0.
REQ-039 Fill DEPTH=4 entries -> pred_ready=0; push plus correct resolve in the same cycle -> count stays 4, fifth entry is at the tail.
REQ-040 Resolve on empty FIFO -> err=1 and stays 1; no flush; cleared only by rst low.
REQ-041 Assert rst during FLUSH -> flush=0 immediately; with BRES_STATS_EN, after 3 branches with 1 mispredict -> stat_branches=3, stat_mispredicts=1.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types for the branch resolver slice.
// Holds the prediction entry, resolver state and instruction size.
package bpu_pkg;

  localparam int INSTR_BYTES = 4;
  // Entry fields are sized for the widest supported PC (WIDTH <= 64).
  localparam int PC_MAX_W = 64;

  typedef enum logic {
    RUN,
    FLUSH
  } bres_state_t;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic                taken;
    logic [PC_MAX_W-1:0] target;
  } pred_entry_t;

endpackage

// File: rtl/pred_fifo.sv
// In-flight prediction queue: push/pop/clear, full/empty, head.
// Ports: clk, rst (async low), push, pop, clear, din, full, empty, head.
module pred_fifo
  import bpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  pred_entry_t din,
  output logic        full,
  output logic        empty,
  output pred_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  pred_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A full queue still takes a push when the head leaves this cycle.
  assign do_push = push && !clear && (!full || do_pop);
  assign do_pop  = pop && !clear && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Checks resolved control flow against queued predictions; flushes on miss.
// Ports: pred_* push, res_* resolve, flush/redirect_pc, upd_* training, err;
// stat_branches/stat_mispredicts exist only when BRES_STATS_EN is defined.
module branch_resolver
  import bpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [WIDTH-1:0] pred_pc,
  input  logic             pred_taken,
  input  logic [WIDTH-1:0] pred_target,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_pc,
  input  logic             res_branch,
  input  logic             res_eq,
  input  logic [WIDTH-1:0] res_target,
  output logic             flush,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             upd_valid,
  output logic [WIDTH-1:0] upd_pc,
  output logic             upd_taken,
  output logic [WIDTH-1:0] upd_target,
  output logic             err
`ifdef BRES_STATS_EN
  ,
  output logic [15:0]      stat_branches,
  output logic [15:0]      stat_mispredicts
`endif
);

  bres_state_t      state;
  bres_state_t      state_nxt;
  pred_entry_t      din;
  pred_entry_t      head;
  logic             full;
  logic             empty;
  logic             run;
  logic             res_fire;
  logic             res_orphan;
  logic             taken;
  logic [WIDTH-1:0] next_pc;
  logic             pc_bad;
  logic             mispredict;
  logic             push;

  assign run        = (state == RUN);
  assign res_fire   = run && res_valid && !empty;
  assign res_orphan = run && res_valid && empty;

  assign taken   = res_branch && res_eq;
  assign next_pc = taken ? res_target
                         : res_pc + WIDTH'(INSTR_BYTES);

  assign pc_bad     = (head.pc != PC_MAX_W'(res_pc));
  assign mispredict = res_fire && (pc_bad
                    || (head.taken != taken)
                    || (taken && head.target != PC_MAX_W'(res_target)));

  // Younger push behind a miss is on the wrong path: drop it.
  assign push       = pred_valid && run && !mispredict;
  assign pred_ready = run && !full;
  assign flush      = (state == FLUSH);

  assign din.pc     = PC_MAX_W'(pred_pc);
  assign din.taken  = pred_taken;
  assign din.target = PC_MAX_W'(pred_target);

  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (res_fire),
    .clear (flush),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      flush:      state_nxt = RUN;
      mispredict: state_nxt = FLUSH;
      default:    state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_pc <= '0;
      upd_valid   <= 1'b0;
      upd_pc      <= '0;
      upd_taken   <= 1'b0;
      upd_target  <= '0;
      err         <= 1'b0;
    end else begin
      if (mispredict) redirect_pc <= next_pc;
      upd_valid <= res_fire && res_branch;
      if (res_fire && res_branch) begin
        upd_pc     <= res_pc;
        upd_taken  <= taken;
        upd_target <= res_target;
      end
      if (res_orphan || (res_fire && pc_bad)) err <= 1'b1;
    end
  end

`ifdef BRES_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (res_fire && res_branch && stat_branches != 16'hFFFF)
        stat_branches <= stat_branches + 16'd1;
      if (mispredict && stat_mispredicts != 16'hFFFF)
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver.
// Linear steps, immediate assertions, summary counts at the end.
module tb_branch_resolver;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         pred_valid;
  logic [W-1:0] pred_pc;
  logic         pred_taken;
  logic [W-1:0] pred_target;
  logic         pred_ready;
  logic         res_valid;
  logic [W-1:0] res_pc;
  logic         res_branch;
  logic         res_eq;
  logic [W-1:0] res_target;
  logic         flush;
  logic [W-1:0] redirect_pc;
  logic         upd_valid;
  logic [W-1:0] upd_pc;
  logic         upd_taken;
  logic [W-1:0] upd_target;
  logic         err;
`ifdef BRES_STATS_EN
  logic [15:0]  stat_branches;
  logic [15:0]  stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolver #(
    .WIDTH (W),
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pred_valid  (pred_valid),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_ready  (pred_ready),
    .res_valid   (res_valid),
    .res_pc      (res_pc),
    .res_branch  (res_branch),
    .res_eq      (res_eq),
    .res_target  (res_target),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .err         (err)
`ifdef BRES_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] pc, input logic tk,
                      input logic [W-1:0] tg);
    pred_valid  = 1'b1;
    pred_pc     = pc;
    pred_taken  = tk;
    pred_target = tg;
    cyc();
    pred_valid  = 1'b0;
  endtask

  task automatic resolve(input logic [W-1:0] pc, input logic br,
                         input logic eq, input logic [W-1:0] tg);
    res_valid  = 1'b1;
    res_pc     = pc;
    res_branch = br;
    res_eq     = eq;
    res_target = tg;
    cyc();
    res_valid  = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    pred_valid  = 1'b0;
    pred_pc     = '0;
    pred_taken  = 1'b0;
    pred_target = '0;
    res_valid   = 1'b0;
    res_pc      = '0;
    res_branch  = 1'b0;
    res_eq      = 1'b0;
    res_target  = '0;
    #12;
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_upd_target", upd_target, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", pred_ready, 1);
    @(posedge clk);
    #1 rst = 1'b1;

    // correct taken prediction
    push(32'h100, 1'b1, 32'h140);
    resolve(32'h100, 1'b1, 1'b1, 32'h140);
    chk("hit_flush", flush, 0);
    chk("hit_upd_valid", upd_valid, 1);
    chk("hit_upd_taken", upd_taken, 1);
    chk("hit_upd_pc", upd_pc, 32'h100);
    chk("hit_upd_target", upd_target, 32'h140);
    cyc();
    chk("hit_upd_pulse", upd_valid, 0);

    // predicted taken, actually not taken
    push(32'h300, 1'b1, 32'h320);
    resolve(32'h300, 1'b1, 1'b0, 32'h320);
    chk("nt_flush", flush, 1);
    chk("nt_redirect", redirect_pc, 32'h304);
    chk("nt_upd_taken", upd_taken, 0);
    cyc();
    chk("nt_flush_end", flush, 0);

    // predicted not taken, actually taken; extra entry must be flushed
    push(32'h200, 1'b0, 32'h204);
    push(32'h204, 1'b0, 32'h208);
    resolve(32'h200, 1'b1, 1'b1, 32'h180);
    chk("tk_flush", flush, 1);
    chk("tk_redirect", redirect_pc, 32'h180);
    chk("tk_ready_flush", pred_ready, 0);
    cyc();
    chk("tk_flush_one", flush, 0);
    chk("tk_ready_run", pred_ready, 1);

    // fill to full, then push alongside a correct resolve
    push(32'h400, 1'b0, 32'h404);
    push(32'h410, 1'b0, 32'h414);
    push(32'h420, 1'b0, 32'h424);
    chk("fill3_ready", pred_ready, 1);
    push(32'h430, 1'b0, 32'h434);
    chk("fill4_ready", pred_ready, 0);
    pred_valid  = 1'b1;
    pred_pc     = 32'h440;
    pred_taken  = 1'b0;
    pred_target = 32'h444;
    resolve(32'h400, 1'b1, 1'b0, 32'h500);
    pred_valid  = 1'b0;
    chk("full_swap_ready", pred_ready, 0);
    chk("full_swap_flush", flush, 0);
    chk("full_swap_upd", upd_valid, 1);
    for (int i = 1; i <= 4; i++) begin
      resolve(32'h400 + 32'(i * 16), 1'b1, 1'b0, 32'h500);
      chk($sformatf("drain%0d_flush", i), flush, 0);
    end
    chk("drain_err", err, 0);
    chk("drain_ready", pred_ready, 1);
`ifdef BRES_STATS_EN
    chk("stat_br_a", stat_branches, 8);
    chk("stat_mp_a", stat_mispredicts, 2);
`endif

    // resolve with nothing in flight
    resolve(32'h900, 1'b1, 1'b1, 32'h940);
    chk("orphan_err", err, 1);
    chk("orphan_flush", flush, 0);
    chk("orphan_upd", upd_valid, 0);
    repeat (3) cyc();
    chk("orphan_sticky", err, 1);

    // reset during the flush cycle
    push(32'h500, 1'b1, 32'h540);
    resolve(32'h500, 1'b1, 1'b0, 32'h540);
    chk("rf_flush", flush, 1);
    #2 rst = 1'b0;
    #1;
    chk("rf_flush_abort", flush, 0);
    chk("rf_err_clr", err, 0);
    chk("rf_upd_clr", upd_valid, 0);
    chk("rf_ready", pred_ready, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc();
    chk("rf_no_flush", flush, 0);
`ifdef BRES_STATS_EN
    chk("stat_br_rst", stat_branches, 0);
    chk("stat_mp_rst", stat_mispredicts, 0);
`endif

    // three branches, last one mispredicted
    push(32'h600, 1'b0, 32'h604);
    push(32'h610, 1'b1, 32'h650);
    push(32'h620, 1'b0, 32'h624);
    resolve(32'h600, 1'b1, 1'b0, 32'h680);
    chk("s1_flush", flush, 0);
    resolve(32'h610, 1'b1, 1'b1, 32'h650);
    chk("s2_flush", flush, 0);
    resolve(32'h620, 1'b1, 1'b1, 32'h700);
    chk("s3_flush", flush, 1);
    chk("s3_redirect", redirect_pc, 32'h700);
    chk("s3_err", err, 0);
    cyc();
`ifdef BRES_STATS_EN
    chk("stat_br", stat_branches, 3);
    chk("stat_mp", stat_mispredicts, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
